// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the registered priority / round-robin arbiter.
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index decrement that wraps at n, not at the next power of two.
    function automatic int unsigned dec_mod(input int unsigned idx, input int unsigned n);
        return (idx == 0) ? (n - 1) : (idx - 1);
    endfunction

endpackage

// File: rtl/prio_arb_rr_if.sv
// Request/grant bundle between the requesters, the consumer and the arbiter.
interface prio_arb_rr_if #(
    parameter int N_REQ = 8
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic             ack;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic             busy;
    logic             timeout;

    modport master (
        output req, ack,
        input  gnt_valid, gnt_idx, gnt_onehot, busy, timeout
    );

    modport slave (
        input  req, ack,
        output gnt_valid, gnt_idx, gnt_onehot, busy, timeout
    );

endinterface

// File: rtl/prio_enc_rot.sv
// Combinational rotated priority encoder: searches i_start, i_start-1, ... modulo N_REQ
// and reports the first set request.
module prio_enc_rot #(
    parameter int N_REQ = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_pos [N_REQ];
    logic [N_REQ-1:0] w_hit;

    // w_pos[gi] is the requester examined gi steps into the search.
    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_pos
        localparam logic [IDX_W:0] OFF = (IDX_W + 1)'(gi);
        logic [IDX_W:0] w_start_ext;
        assign w_start_ext = {1'b0, i_start};
        assign w_pos[gi] = (w_start_ext >= OFF)
                         ? IDX_W'(w_start_ext - OFF)
                         : IDX_W'(w_start_ext + (IDX_W + 1)'(N_REQ) - OFF);
        assign w_hit[gi] = i_req[w_pos[gi]];
    end

    assign o_found = |w_hit;

    always_comb begin
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_pos[k];
            end
        end
    end

endmodule

// File: rtl/prio_arb_rr.sv
// Registered N_REQ-way arbiter (fixed priority or round-robin) with grant/ack handshake.
// Optional grant watchdog enabled by defining PRIO_ARB_TIMEOUT_EN.
module prio_arb_rr
    import prio_arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int MODE    = MODE_FIXED,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    prio_arb_rr_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ - 1){1'b0}}, 1'b1};

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("prio_arb_rr: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_t       r_state, w_state_next;
    logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_next;
    logic [N_REQ-1:0] r_gnt_onehot, w_gnt_onehot_next;
    logic [IDX_W-1:0] r_lptr, w_lptr_next;
    logic             r_timeout, w_timeout_next;

    logic [IDX_W-1:0] w_lptr_eff;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_new_grant;
    logic             w_expire;

    // In an ack cycle the search must already see the just-finished grant as lptr.
    assign w_lptr_eff = (r_state == GRANT) ? r_gnt_idx : r_lptr;
    assign w_start    = (MODE == MODE_RR)
                      ? IDX_W'(dec_mod(32'(w_lptr_eff), 32'(N_REQ)))
                      : IDX_W'(N_REQ - 1);

    prio_enc_rot #(
        .N_REQ (N_REQ)
    ) u_enc (
        .i_req   (bus.req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win)
    );

`ifdef PRIO_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog, w_wdog_next;

    // Expiry fires on the edge at which the count would reach TIMEOUT.
    assign w_expire = (r_state == GRANT) && !bus.ack && (r_wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_wdog_next = '0;
        if ((r_state == GRANT) && !bus.ack && !w_expire) begin
            w_wdog_next = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_gnt_idx_next    = r_gnt_idx;
        w_gnt_onehot_next = r_gnt_onehot;
        w_lptr_next       = r_lptr;
        w_timeout_next    = 1'b0;
        w_new_grant       = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt_idx_next    = '0;
                w_gnt_onehot_next = '0;
                w_new_grant       = w_found;
            end
            GRANT: begin
                // Without ack nothing here looks at req, so the grant stays frozen.
                if (bus.ack) begin
                    w_lptr_next = r_gnt_idx;
                    if (w_found) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_next      = IDLE;
                        w_gnt_idx_next    = '0;
                        w_gnt_onehot_next = '0;
                    end
                end else if (w_expire) begin
                    w_lptr_next       = r_gnt_idx;
                    w_state_next      = IDLE;
                    w_gnt_idx_next    = '0;
                    w_gnt_onehot_next = '0;
                    w_timeout_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_new_grant) begin
            w_state_next      = GRANT;
            w_gnt_idx_next    = w_win;
            w_gnt_onehot_next = ONE << w_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_lptr       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_gnt_idx    <= w_gnt_idx_next;
            r_gnt_onehot <= w_gnt_onehot_next;
            r_lptr       <= w_lptr_next;
            r_timeout    <= w_timeout_next;
        end
    end

    assign bus.gnt_valid  = (r_state == GRANT);
    assign bus.busy       = (r_state == GRANT);
    assign bus.gnt_idx    = r_gnt_idx;
    assign bus.gnt_onehot = r_gnt_onehot;
    assign bus.timeout    = r_timeout;

endmodule

// File: doc/prio_arb_rr.md
Name: prio_arb_rr

Overview:
- Parametrised, registered successor to the 4-to-3 priority encoder.
- Encodes an N_REQ-wide request vector into a held grant, output both as a binary index and as one-hot.
- Supports fixed-priority or round-robin arbitration, with a grant/ack handshake.
- Sits between multiple requesters and one shared resource; the grant stays stable until the consumer acknowledges it.

Parameters:
- N_REQ, 8: number of request lines, ≥2.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- TIMEOUT, 16: cycles a grant may be held without ack (used only with the optional feature), ≥1.
- IDX_W, $clog2(N_REQ): localparam giving the index width.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, N_REQ: request lines; bit i is requester i.
- ack, input, 1: consumer done with the current grant; sampled only in GRANT.
- gnt_valid, output, 1: a grant is active.
- gnt_idx, output, IDX_W: binary index of the granted requester.
- gnt_onehot, output, N_REQ: one-hot grant; equals 1<<gnt_idx when gnt_valid=1, else 0.
- busy, output, 1: FSM is in GRANT.
- timeout, output, 1: one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values, all outputs: gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0, timeout=0.
- Reset values, internal state: state=IDLE, last-grant pointer lptr=0, watchdog counter=0.
- All outputs are registered. There is no combinational path from req or ack to any output.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req≠0: select winner w, register gnt_idx=w, gnt_onehot=1<<w, gnt_valid=1, busy=1, and go to GRANT.
  - Latency: request sampled at edge k, grant visible after edge k.
  - If req=0: stay in IDLE with outputs cleared.
- GRANT:
  - Outputs are frozen regardless of req changes, including withdrawal of the granted request.
  - On ack=1, set lptr=gnt_idx.
  - If req≠0 in the ack cycle, the new winner is registered at the same edge (back-to-back, zero bubble) and the FSM stays in GRANT.
  - If req=0 in the ack cycle, go to IDLE; gnt_valid=0 from the next cycle.
  - Winner selection in the ack cycle uses the updated lptr.
- Fixed mode (MODE=0):
  - Winner = highest set bit of req.
  - lptr is unused.
  - For N_REQ=4 this reproduces the 4-to-3 encoder: {gnt_valid, gnt_idx} = {|req, msb index}.
- Round-robin mode (MODE=1):
  - Search order is lptr-1, lptr-2, …, 0, N_REQ-1, …, lptr, modulo N_REQ. The last granted requester has lowest priority.
  - lptr=0 after reset, so the first search starts at N_REQ-1 and matches fixed mode.
- Non-power-of-two N_REQ: index wrap is done modulo N_REQ, never modulo 2^IDX_W. Unused index codes never appear on gnt_idx.
- Simultaneous ack and watchdog expiry: ack wins; timeout is not asserted.
- X on req while in GRANT must not disturb the outputs.

Optional Feature:
- Macro: PRIO_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and on every new grant, and increments each GRANT cycle without ack.
  - When the counter reaches TIMEOUT with ack=0, the grant is revoked: lptr is updated as if acked, the FSM goes to IDLE, gnt_valid=0, and timeout pulses for one cycle, all at the same edge.
  - Re-arbitration happens from IDLE on the following cycle.
- Undefined:
  - No counter is built; timeout is tied to 0.
  - A grant is held indefinitely until ack.

Decomposition:
- Package prio_arb_pkg contains:
  - the state enum (IDLE, GRANT);
  - the mode constants MODE_FIXED=0 and MODE_RR=1;
  - a function computing the wrap-safe decrement modulo N_REQ.
- One sub-module, prio_enc_rot: a combinational rotated priority encoder.
  - Inputs: req and a start index.
  - Outputs: found and idx.
  - Instantiated once; the top module holds the FSM, the registers, lptr and the watchdog.

Test Plan:
- Reset: hold rst_n=0 with req=0xFF → all outputs 0. Deassert rst_n → gnt_valid=1, gnt_idx=7 one cycle later.
- Fixed, N_REQ=4: sweep req 0..15, pulsing ack each grant → gnt_valid=0 for req=0; otherwise gnt_idx = msb index (e.g. req=0b0110 → 2, req=0b1001 → 3).
- Hold check: MODE=0, N_REQ=8, req=0x26 → gnt_idx=5, onehot=0x20. Change req to 0x01 without ack → outputs unchanged for 10 cycles. Then ack → gnt_idx=0 next cycle.
- Round-robin: MODE=1, req=0xFF held, ack every cycle → grants 7,6,5,4,3,2,1,0,7 on consecutive cycles with no bubble.
- Ack with req=0 → gnt_valid=0 and busy=0 the next cycle. Mid-grant reset (rst_n low during GRANT) → outputs clear immediately; then req=0xFF → gnt_idx=7.
- With PRIO_ARB_TIMEOUT_EN, TIMEOUT=4: grant, no ack → after 4 GRANT cycles, timeout=1 for one cycle and gnt_valid=0. Repeat with ack on cycle 4 → no timeout pulse.
